// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider with pulse and 50% square outputs.
module clk_div_prog #(
  parameter int CNT_W        = 8,
  parameter int DEFAULT_DIV  = 4,
  parameter bit DEFAULT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_i,
  input  logic             mode_i,
  output logic             clk_out,
  output logic             period_tick,
  output logic [CNT_W-1:0] div_cur,
  output logic             mode_cur,
  output logic             cfg_err
);
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, sh_div_q, sh_div_d, half;
  logic mode_q, mode_d, sh_mode_q, sh_mode_d, pend_q, pend_d;
  logic p_q, p_d, n_q, tick_q, err_q, load_ok, wrap, apply, odd;
  always_comb begin
    load_ok   = load & (div_i > ONE);
    wrap      = en & (cnt_q == div_q - ONE);
    apply     = (pend_q | load_ok) & (wrap | ~en);
    odd       = mode_q & div_q[0];
    half      = (div_q >> 1) + {{(CNT_W-1){1'b0}}, div_q[0]};
    cnt_d     = (en & ~wrap) ? cnt_q + ONE : '0;
    p_d       = en & (mode_q ? (cnt_q < half) : (cnt_q == '0));
    sh_div_d  = load_ok ? div_i : sh_div_q;
    sh_mode_d = load_ok ? mode_i : sh_mode_q;
    pend_d    = ~apply & (pend_q | load_ok);
    div_d     = apply ? sh_div_d : div_q;
    mode_d    = apply ? sh_mode_d : mode_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      div_q     <= DEF_DIV;
      mode_q    <= DEFAULT_MODE;
      sh_div_q  <= DEF_DIV;
      sh_mode_q <= DEFAULT_MODE;
      pend_q    <= 1'b0;
      p_q       <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
      sh_div_q  <= sh_div_d;
      sh_mode_q <= sh_mode_d;
      pend_q    <= pend_d;
      p_q       <= p_d;
      tick_q    <= wrap;
      err_q     <= load & ~load_ok;
    end
  end
  // Half-cycle delayed copy of p; p & n trims the high phase by half a clock for odd N.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) n_q <= 1'b0;
    else n_q <= odd & p_q;
  end
  assign clk_out     = p_q & (n_q | ~odd);
  assign period_tick = tick_q;
  assign div_cur     = div_q;
  assign mode_cur    = mode_q;
  assign cfg_err     = err_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: scoreboard bench for the programmable clock divider.
module tb_clk_div_prog;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0, mode_i = 1'b0;
  logic [7:0] div_i = '0;
  logic clk_out, period_tick, mode_cur, cfg_err;
  logic [7:0] div_cur;
  int pass_cnt = 0, total = 0, c = 0;
  logic [1:0] sb[$];

  clk_div_prog #(.CNT_W(8), .DEFAULT_DIV(4), .DEFAULT_MODE(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .div_i(div_i), .mode_i(mode_i),
    .clk_out(clk_out), .period_tick(period_tick), .div_cur(div_cur),
    .mode_cur(mode_cur), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected output after the edge at count position c, for ratio n and mode m.
  task automatic chk_edge(input int n, input bit m);
    bit odd, ec;
    int h;
    logic [1:0] e;
    h = (n + 1) / 2;
    odd = m && (n % 2 == 1);
    ec = m ? (c < h && (!odd || (c > 0 && c - 1 < h))) : (c == 0);
    sb.push_back({ec, c == n - 1});
    step();
    e = sb.pop_front();
    total++;
    if (clk_out !== e[1]) $display("FAIL clk_out n=%0d m=%0d c=%0d got %b exp %b", n, m, c, clk_out, e[1]);
    else pass_cnt++;
    total++;
    if (period_tick !== e[0]) $display("FAIL period_tick n=%0d c=%0d got %b exp %b", n, c, period_tick, e[0]);
    else pass_cnt++;
    c = (c + 1) % n;
  endtask

  task automatic chk_cfg(input string tag, input int d, input bit m);
    total++;
    if (div_cur !== 8'(d)) $display("FAIL %s div_cur got %0d exp %0d", tag, div_cur, d);
    else pass_cnt++;
    total++;
    if (mode_cur !== m) $display("FAIL %s mode_cur got %b exp %b", tag, mode_cur, m);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({clk_out, period_tick, cfg_err} !== 3'b000) $display("FAIL reset outputs got %b exp 000", {clk_out, period_tick, cfg_err});
    else pass_cnt++;
    step();
    step();
    chk_cfg("reset", 4, 1'b0);
  endtask

  task automatic test_pulse();
    rst = 1'b0;
    en = 1'b1;
    c = 0;
    for (int i = 0; i < 13; i++) chk_edge(4, 1'b0);
    chk_cfg("pulse", 4, 1'b0);
  endtask

  task automatic test_load_mid();
    load = 1'b1; div_i = 8'd6; mode_i = 1'b1;
    chk_edge(4, 1'b0);
    load = 1'b0;
    chk_edge(4, 1'b0);
    chk_cfg("load_mid_before", 4, 1'b0);
    chk_edge(4, 1'b0);
    chk_cfg("load_mid_after", 6, 1'b1);
    for (int i = 0; i < 12; i++) chk_edge(6, 1'b1);
  endtask

  task automatic test_odd_square();
    int k, hi, rises;
    logic prev;
    load = 1'b1; div_i = 8'd5; mode_i = 1'b1;
    chk_edge(6, 1'b1);
    load = 1'b0;
    while (c != 0) chk_edge(6, 1'b1);
    chk_cfg("odd", 5, 1'b1);
    hi = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      k = c;
      chk_edge(5, 1'b1);
      if (clk_out && !prev) rises++;
      hi += int'(clk_out);
      prev = clk_out;
      @(negedge clk);
      #1;
      total++;
      if (clk_out !== (k < 3)) $display("FAIL odd_negedge c=%0d got %b exp %b", k, clk_out, k < 3);
      else pass_cnt++;
      if (clk_out && !prev) rises++;
      hi += int'(clk_out);
      prev = clk_out;
    end
    total++;
    if (hi != 10) $display("FAIL odd_duty high half-cycles got %0d exp 10", hi);
    else pass_cnt++;
    total++;
    if (rises != 2) $display("FAIL odd_glitch rising edges got %0d exp 2", rises);
    else pass_cnt++;
  endtask

  task automatic test_bad_load();
    for (int i = 0; i < 2; i++) begin
      load = 1'b1; div_i = 8'(1 - i); mode_i = 1'b0;
      chk_edge(5, 1'b1);
      total++;
      if (cfg_err !== 1'b1) $display("FAIL cfg_err_set div=%0d got %b exp 1", 1 - i, cfg_err);
      else pass_cnt++;
      load = 1'b0;
      chk_edge(5, 1'b1);
      total++;
      if (cfg_err !== 1'b0) $display("FAIL cfg_err_clear div=%0d got %b exp 0", 1 - i, cfg_err);
      else pass_cnt++;
    end
    chk_cfg("bad_load", 5, 1'b1);
  endtask

  task automatic test_back_to_back();
    load = 1'b1; div_i = 8'd8; mode_i = 1'b0;
    chk_edge(5, 1'b1);
    load = 1'b0;
    while (c != 0) chk_edge(5, 1'b1);
    chk_cfg("b2b_n8", 8, 1'b0);
    chk_edge(8, 1'b0);
    chk_edge(8, 1'b0);
    load = 1'b1; div_i = 8'd3; mode_i = 1'b0;
    chk_edge(8, 1'b0);
    load = 1'b0;
    while (c != 7) chk_edge(8, 1'b0);
    load = 1'b1; div_i = 8'd7; mode_i = 1'b1;
    chk_cfg("b2b_pre_wrap", 8, 1'b0);
    chk_edge(8, 1'b0);
    load = 1'b0;
    chk_cfg("b2b_post_wrap", 7, 1'b1);
    for (int i = 0; i < 14; i++) chk_edge(7, 1'b1);
  endtask

  task automatic test_enable();
    for (int i = 0; i < 3; i++) chk_edge(7, 1'b1);
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({clk_out, period_tick} !== 2'b00) $display("FAIL en_off cycle %0d got %b exp 00", i, {clk_out, period_tick});
      else pass_cnt++;
    end
    load = 1'b1; div_i = 8'd6; mode_i = 1'b1;
    step();
    load = 1'b0;
    chk_cfg("en_off_load", 6, 1'b1);
    en = 1'b1;
    c = 0;
    for (int i = 0; i < 13; i++) chk_edge(6, 1'b1);
  endtask

  task automatic test_reset_mid();
    load = 1'b1; div_i = 8'd9; mode_i = 1'b0;
    chk_edge(6, 1'b1);
    load = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({clk_out, period_tick} !== 2'b00) $display("FAIL rst_mid outputs got %b exp 00", {clk_out, period_tick});
    else pass_cnt++;
    chk_cfg("rst_mid", 4, 1'b0);
    step();
    rst = 1'b0;
    c = 0;
    for (int i = 0; i < 10; i++) chk_edge(4, 1'b0);
    chk_cfg("rst_discard", 4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_pulse();
    test_load_mid();
    test_odd_square();
    test_bad_load();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
